// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;
  localparam int IMEM_DEPTH = 128;
  localparam int IMEM_DW    = 32;
  localparam int IMEM_AW    = $clog2(IMEM_DEPTH);
  localparam logic [5:0] HALT_OP = 6'b111000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  // Header is a word count: 1..depth words are loadable.
  function automatic logic hdr_ok(input logic [7:0] n, input int depth);
    return (n != 8'd0) && (int'(n) <= depth);
  endfunction
endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port out.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word; flags the 4th byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift,
  input  logic [7:0]         din,
  output logic [IMEM_DW-1:0] word,
  output logic               word_valid
);
  logic [1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clr) begin
      idx  <= '0;
    end else if (shift) begin
      word <= {word[IMEM_DW-9:0], din};
      idx  <= idx + 2'd1;
    end
  end

  // Combinational so the FSM can enter WRITE on the same edge that takes byte 4;
  // idx wraps to 0 on that edge, ready for the next word.
  assign word_valid = shift && (idx == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, one word per write.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rsta_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   word_cnt
);
  state_t              state, state_nxt;
  logic [AW-1:0]       addr;
  logic [AW:0]         n_words;
  logic [AW:0]         cnt_inc;
  logic                xfer, hdr_acc, wr_last;
  logic [IMEM_DW-1:0]  word;
  logic                word_valid;

  assign xfer    = bus.in_valid && bus.in_ready;
  assign hdr_acc = (state == ST_HDR) && xfer && hdr_ok(bus.in_data, DEPTH);
  assign cnt_inc = word_cnt + {{AW{1'b0}}, 1'b1};
  assign wr_last = (cnt_inc == n_words);

  byte_packer u_pack (
    .clk        (clk),
    .rst_n      (rsta_n),
    .clr        (hdr_acc),
    .shift      (xfer && (state == ST_DATA)),
    .din        (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rsta_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_HDR;
      ST_HDR:   if (xfer) state_nxt = hdr_acc ? ST_DATA : ST_ERR;
      ST_DATA:  if (word_valid) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = wr_last ? ST_DONE : ST_DATA;
      ST_DONE:  if (start) state_nxt = ST_HDR;
      ST_ERR:   if (start) state_nxt = ST_HDR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rsta_n) begin
      addr     <= '0;
      word_cnt <= '0;
      n_words  <= '0;
    end else if (hdr_acc) begin
      addr     <= '0;
      word_cnt <= '0;
      n_words  <= (AW+1)'(bus.in_data);
    end else if (state == ST_WRITE) begin
      word_cnt <= cnt_inc;
      // Stop at the last word so a full-depth load leaves addr at DEPTH-1.
      if (!wr_last) addr <= addr + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    bus.in_ready  = (state == ST_HDR) || (state == ST_DATA);
    bus.mem_we    = (state == ST_WRITE);
    bus.mem_addr  = {{(32-AW){1'b0}}, addr};
    bus.mem_wdata = word;
    busy          = (state == ST_HDR) || (state == ST_DATA) || (state == ST_WRITE);
    done          = (state == ST_DONE);
    err           = (state == ST_ERR);
  end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench: expected writes are queued as bytes are driven, checked on mem_we.
module tb_imem_loader;
  import imem_pkg::*;

  logic       clk = 1'b0;
  logic       rsta_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, err;
  logic [7:0] word_cnt;
  int         checks = 0;
  int         failures = 0;
  wr_t        sb[$];

  imem_loader_if bus ();

  imem_loader dut (
    .clk      (clk),
    .rsta_n   (rsta_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rsta_n && bus.mem_we === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    bit rdy;
    if (gap) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    do begin
      rdy = bus.in_ready;
      tick();
      n++;
    end while (!rdy && n < 40);
    if (!rdy) chk("hs_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input bit gap);
    wr_t e;
    e.addr = addr;
    e.data = w;
    sb.push_back(e);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gap);
    chk("we_latency", {31'd0, bus.mem_we}, 32'd1);
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      tick();
      n++;
    end
    if (!(done || err)) chk("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rsta_n = 1'b0;
    repeat (2) tick();
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_we",    {31'd0, bus.mem_we},   32'd0);
    chk("rst_busy",  {31'd0, busy},         32'd0);
    chk("rst_done",  {31'd0, done},         32'd0);
    chk("rst_err",   {31'd0, err},          32'd0);
    chk("rst_cnt",   {24'd0, word_cnt},     32'd0);
    chk("rst_addr",  bus.mem_addr,          32'd0);
    rsta_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] w;
    wr_t e;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    do_reset();

    // Basic two-word load
    pulse_start();
    chk("hdr_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h02, 1'b0);
    send_word(32'd0, 32'h20010012, 1'b0);
    send_word(32'd1, 32'h2002000C, 1'b0);
    wait_end(20);
    chk("load_done", {31'd0, done}, 32'd1);
    chk("load_cnt",  {24'd0, word_cnt}, 32'd2);
    chk("load_busy", {31'd0, busy}, 32'd0);
    chk("load_err",  {31'd0, err}, 32'd0);
    chk("load_sb",   sb.size(), 32'd0);

    // Bad headers
    pulse_start();
    chk("restart_done", {31'd0, done}, 32'd0);
    send_byte(8'h00, 1'b0);
    chk("n0_err",  {31'd0, err}, 32'd1);
    chk("n0_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    chk("err_clear", {31'd0, err}, 32'd0);
    send_byte(8'h81, 1'b0);
    chk("n129_err", {31'd0, err}, 32'd1);
    chk("n129_cnt", {24'd0, word_cnt}, 32'd2);

    // Backpressure: valid low every other cycle
    pulse_start();
    send_byte(8'h02, 1'b1);
    send_word(32'd0, 32'h20010012, 1'b1);
    send_word(32'd1, 32'h2002000C, 1'b1);
    wait_end(20);
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_cnt",  {24'd0, word_cnt}, 32'd2);
    chk("bp_sb",   sb.size(), 32'd0);

    // Reset in the middle of a word
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_reset();
    repeat (4) tick();
    chk("midrst_sb", sb.size(), 32'd0);

    // start with a byte in the same IDLE cycle: byte is not taken as header
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("idle_hdr_ready", {31'd0, bus.in_ready}, 32'd1);
    send_byte(8'h01, 1'b0);
    send_word(32'd0, 32'hDEADBEEF, 1'b0);
    wait_end(10);
    chk("fresh_done", {31'd0, done}, 32'd1);
    chk("fresh_cnt",  {24'd0, word_cnt}, 32'd1);

    // Full-depth load with a start pulse while busy
    pulse_start();
    send_byte(8'h80, 1'b0);
    w = {HALT_OP, 26'($urandom)};
    e.addr = 32'd0;
    e.data = w;
    sb.push_back(e);
    send_byte(w[31:24], 1'b0);
    pulse_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[7:0], 1'b0);
    chk("full_w0_we", {31'd0, bus.mem_we}, 32'd1);
    for (int i = 1; i < IMEM_DEPTH; i++) send_word(32'(i), $urandom, (i % 7) == 3);
    wait_end(20);
    chk("full_done",  {31'd0, done}, 32'd1);
    chk("full_cnt",   {24'd0, word_cnt}, 32'd128);
    chk("full_last",  bus.mem_addr, 32'd127);
    chk("full_sb",    sb.size(), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    tick();
    chk("done_noready", {31'd0, bus.in_ready}, 32'd0);
    chk("done_hold", {31'd0, done}, 32'd1);
    bus.in_valid = 1'b0;
    pulse_start();
    chk("rehdr_done",  {31'd0, done}, 32'd0);
    chk("rehdr_busy",  {31'd0, busy}, 32'd1);
    chk("rehdr_ready", {31'd0, bus.in_ready}, 32'd1);

    repeat (3) tick();
    chk("final_sb", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
